// File: rtl/gate_array_pipe_if.sv
// gate_array_pipe_if: operand/result bus for gate_array_pipe.
//   in_valid/in_ready : operand-set handshake (producer -> block)
//   in_data           : NIN lanes, lane i at [i*WIDTH +: WIDTH]
//   in_en             : per-lane participation mask
//   in_op             : 0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 XNOR,6 BUF,7 NOT
//   out_valid/out_ready, out_data : result handshake (block -> consumer)
//   result_count      : results delivered, wrapping 16-bit
// Modports: slave = the block, master = producer/consumer side.
interface gate_array_pipe_if #(
  parameter int WIDTH = 32,
  parameter int NIN   = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NIN*WIDTH-1:0]  in_data;
  logic [NIN-1:0]        in_en;
  logic [2:0]            in_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [15:0]           result_count;

  modport slave (
    input  in_valid, in_data, in_en, in_op, out_ready,
    output in_ready, out_valid, out_data, result_count
  );

  modport master (
    output in_valid, in_data, in_en, in_op, out_ready,
    input  in_ready, out_valid, out_data, result_count
  );
endinterface

// File: rtl/gate_array_pipe.sv
// gate_array_pipe: two-stage, back-pressured N-input bitwise gate array.
//   S1 registers the operand set (data, mask, op); S2 registers the reduced
//   result. Disabled lanes are replaced by the identity of the reduction
//   (ones for AND/NAND, zero for OR/NOR/XOR/XNOR). BUF/NOT use lane 0 and
//   ignore the mask. Capacity is two operand sets in flight.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : gate_array_pipe_if.slave (in_*/out_* handshakes, result_count)
// Optional build macro GATE_ARRAY_PIPE_ASSERT_EN: adds a shadow reference
//   pipeline and immediate assertions out_ok / stable_ok / cap_ok. Port
//   behaviour is the same with or without it.

// One lane: substitute the reduction identity when the lane is masked off.
module gate_array_lane #(
  parameter int W = 32
) (
  input  logic [W-1:0] d,
  input  logic         en,
  output logic [W-1:0] and_term,
  output logic [W-1:0] or_term
);
  assign and_term = en ? d : '1;
  assign or_term  = en ? d : '0;
endmodule

module gate_array_pipe #(
  parameter int WIDTH = 32,
  parameter int NIN   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  gate_array_pipe_if.slave bus
);
  localparam int STAGES = 2;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0, OP_OR  = 3'd1, OP_XOR  = 3'd2, OP_NAND = 3'd3,
    OP_NOR  = 3'd4, OP_XNOR = 3'd5, OP_BUF = 3'd6, OP_NOT  = 3'd7
  } op_e;

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied
  logic [STAGES:1]               vld_pipe;
  logic [NIN-1:0][WIDTH-1:0]     s1_data;
  logic [NIN-1:0]                s1_en;
  op_e                           s1_op;
  logic [WIDTH-1:0]              s2_data;
  logic [15:0]                   cnt;

  logic s1_valid, s2_valid, s1_advance, s2_advance, in_ready, accept, take;
  logic [NIN-1:0][WIDTH-1:0]     in_lanes;

  assign s1_valid   = vld_pipe[1];
  assign s2_valid   = vld_pipe[2];
  assign s2_advance = !s2_valid || bus.out_ready;
  assign s1_advance = s1_valid && s2_advance;
  assign in_ready   = !s1_valid || s2_advance;
  assign accept     = bus.in_valid && in_ready;
  assign take       = s2_valid && bus.out_ready;
  assign in_lanes   = bus.in_data;

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = s2_valid;
  assign bus.out_data     = s2_data;
  assign bus.result_count = cnt;

  // ---------------- per-lane masking ----------------
  logic [NIN-1:0][WIDTH-1:0] and_t, or_t;

  for (genvar i = 0; i < NIN; i++) begin : g_lane
    gate_array_lane #(.W(WIDTH)) u_lane (
      .d        (s1_data[i]),
      .en       (s1_en[i]),
      .and_term (and_t[i]),
      .or_term  (or_t[i])
    );
  end

  // ---------------- reduction + op select ----------------
  logic [WIDTH-1:0] red_and, red_or, red_xor, result;

  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int i = 0; i < NIN; i++) begin
      red_and = red_and & and_t[i];
      red_or  = red_or  | or_t[i];
      red_xor = red_xor ^ or_t[i];
    end
    result = '0;
    case (s1_op)
      OP_AND:  result = red_and;
      OP_OR:   result = red_or;
      OP_XOR:  result = red_xor;
      OP_NAND: result = ~red_and;
      OP_NOR:  result = ~red_or;
      OP_XNOR: result = ~red_xor;
      OP_BUF:  result = s1_data[0];
      OP_NOT:  result = ~s1_data[0];
      default: result = '0;
    endcase
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s1_en    <= '0;
      s1_op    <= OP_AND;
      s2_data  <= '0;
      cnt      <= '0;
    end else begin
      // S1 may refill in the same cycle it drains into S2
      if (in_ready) vld_pipe[1] <= bus.in_valid;
      if (accept) begin
        s1_data <= in_lanes;
        s1_en   <= bus.in_en;
        s1_op   <= op_e'(bus.in_op);
      end
      if (s2_advance) vld_pipe[2] <= s1_valid;
      if (s1_advance) s2_data <= result;
      if (take) cnt <= cnt + 16'd1;
    end
  end

`ifdef GATE_ARRAY_PIPE_ASSERT_EN
  // Bit-serial reference, structured differently from the datapath above.
  function automatic logic [WIDTH-1:0] ref_reduce(
    input logic [NIN-1:0][WIDTH-1:0] d,
    input logic [NIN-1:0]            en,
    input logic [2:0]                op
  );
    logic [WIDTH-1:0] r;
    logic a, o, x;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      a = 1'b1; o = 1'b0; x = 1'b0;
      for (int i = 0; i < NIN; i++) begin
        if (en[i]) begin
          a = a & d[i][b];
          o = o | d[i][b];
          x = x ^ d[i][b];
        end
      end
      case (op)
        3'd0: r[b] = a;
        3'd1: r[b] = o;
        3'd2: r[b] = x;
        3'd3: r[b] = !a;
        3'd4: r[b] = !o;
        3'd5: r[b] = !x;
        3'd6: r[b] = d[0][b];
        default: r[b] = !d[0][b];
      endcase
    end
    return r;
  endfunction

  logic [WIDTH-1:0] sh1, sh2, hold_data;
  logic             hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh1       <= '0;
      sh2       <= '0;
      hold_q    <= 1'b0;
      hold_data <= '0;
    end else begin
      if (accept)     sh1 <= ref_reduce(in_lanes, bus.in_en, bus.in_op);
      if (s1_advance) sh2 <= sh1;
      hold_q    <= s2_valid && !bus.out_ready;
      hold_data <= s2_data;
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      out_ok: assert (!s2_valid || s2_data == sh2)
        else $error("out_ok: out_data %h ref %h", s2_data, sh2);
      stable_ok: assert (!hold_q || (s2_valid && s2_data == hold_data))
        else $error("stable_ok: output changed while stalled");
      cap_ok: assert (!(s1_valid && !s2_advance) || s2_valid)
        else $error("cap_ok: pipeline overflow");
    end
  end
`endif

endmodule

// File: tb/tb_gate_array_pipe.sv
module tb_gate_array_pipe;
  localparam int WIDTH = 8;
  localparam int NIN   = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  gate_array_pipe_if #(.WIDTH(WIDTH), .NIN(NIN)) bus ();

  gate_array_pipe #(.WIDTH(WIDTH), .NIN(NIN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, when all inputs
  // (driven at the falling edge) and registers are settled; a sample with
  // out_valid && out_ready is exactly one take at the next rising edge.
  always @(negedge clk) begin
    #2;
    if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected none", bus.out_data);
      end else begin
        chk("out_data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Offer one set (called just after a falling edge); pushes the expected
  // result at the accepting edge, returns just after the following falling edge.
  task automatic send(input logic [23:0] data, input logic [2:0] en,
                      input logic [2:0] op, input logic [7:0] exp);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_en    = en;
    bus.in_op    = op;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      done = (bus.in_ready === 1'b1);
      @(posedge clk);
      if (done) exp_q.push_back(exp);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_en     = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_count", bus.result_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // AND, with latency check
    send({8'hFF, 8'h3C, 8'hF0}, 3'b111, 3'd0, 8'h30);
    chk("lat_and_s1", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_and_s2", bus.out_valid, 1);
    @(negedge clk);
    chk("count_after_and", bus.result_count, 1);

    // single-lane NOR, two-lane XNOR
    send({8'h00, 8'h0F, 8'h00}, 3'b010, 3'd4, 8'hF0);
    send({8'h00, 8'h55, 8'hAA}, 3'b011, 3'd5, 8'h00);
    // empty mask
    send({8'h12, 8'h34, 8'h56}, 3'b000, 3'd0, 8'hFF);
    send({8'h12, 8'h34, 8'h56}, 3'b000, 3'd1, 8'h00);
    send({8'h12, 8'h34, 8'h56}, 3'b000, 3'd2, 8'h00);
    send({8'h12, 8'h34, 8'h56}, 3'b000, 3'd3, 8'h00);
    send({8'h12, 8'h34, 8'h56}, 3'b000, 3'd4, 8'hFF);
    send({8'h12, 8'h34, 8'h56}, 3'b000, 3'd5, 8'hFF);
    send({8'h00, 8'h00, 8'h5A}, 3'b000, 3'd6, 8'h5A);
    send({8'h00, 8'h00, 8'h5A}, 3'b000, 3'd7, 8'hA5);
    send({8'hC0, 8'h0C, 8'h81}, 3'b101, 3'd2, 8'h41);
    drain(4);
    chk("count_after_dir", bus.result_count, 12);

    // back-pressure: two accepted, third stalls, then take + accept together
    bus.out_ready = 1'b0;
    send({8'h03, 8'h02, 8'h01}, 3'b111, 3'd1, 8'h03);
    send({8'h40, 8'h20, 8'h10}, 3'b111, 3'd1, 8'h70);
    bus.in_valid = 1'b1;
    bus.in_data  = {8'hFF, 8'h3C, 8'h0F};
    bus.in_en    = 3'b111;
    bus.in_op    = 3'd0;
    #1;
    chk("bp_in_ready_full", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    held = bus.out_data;
    chk("bp_head", {24'd0, held}, 32'h03);
    @(negedge clk);
    #1;
    chk("bp_still_stalled", bus.in_ready, 0);
    chk("bp_stable", {24'd0, bus.out_data}, {24'd0, held});
    chk("bp_valid_held", bus.out_valid, 1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_on_take", bus.in_ready, 1);
    @(posedge clk);
    exp_q.push_back(8'h0C);
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain(4);
    chk("count_after_bp", bus.result_count, 15);

    // reset mid-flight
    bus.out_ready = 1'b0;
    send({8'h01, 8'h01, 8'h01}, 3'b111, 3'd0, 8'h01);
    send({8'h02, 8'h02, 8'h02}, 3'b111, 3'd1, 8'h02);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_count", bus.result_count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    send({8'h00, 8'h00, 8'hC3}, 3'b000, 3'd7, 8'h3C);
    chk("post_rst_s1", bus.out_valid, 0);
    @(negedge clk);
    chk("post_rst_s2", bus.out_valid, 1);
    drain(3);
    chk("post_rst_count", bus.result_count, 1);

    // wrap: clear, then 65536 back-to-back results
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] v;
      v = 16'(i);
      send({8'h00, v[15:8], v[7:0]}, 3'b111, 3'd2, v[7:0] ^ v[15:8]);
    end
    drain(4);
    chk("wrap_count", bus.result_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
